// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, shifts one command byte out on
// device clock falling edges, checks the device ACK and reports done or timeout error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_WAIT_IDLE, S_DONE, S_FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             byte_q, byte_d;
  logic [IW-1:0]          inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   clk_drv_q, clk_drv_d;
  logic                   dat_drv_q, dat_drv_d;
  logic                   ack_q, ack_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  logic       clk_s, dat_s, fe, timeout, par;
  logic [3:0] bit_n;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
    clk_s      = clk_sync_q[SYNC_STAGES-1];
    dat_s      = dat_sync_q[SYNC_STAGES-1];
    clk_prev_d = clk_s;
    fe         = clk_prev_q & ~clk_s;
    timeout    = (to_cnt_q == TO_LAST);
    par        = ~^byte_q;
    bit_n      = bit_cnt_q + 4'd1;
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    ack_d     = ack_q;
    case (state_q)
      S_IDLE: begin
        if (send) begin
          byte_d    = tx_byte;
          ack_d     = 1'b0;
          inh_cnt_d = '0;
          clk_drv_d = 1'b1;
          dat_drv_d = (INHIBIT_CYCLES == 1);
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        // The start bit is pulled low in the last inhibit cycle, before clk is released.
        if (inh_cnt_q == INH_LAST) begin
          clk_drv_d = 1'b0;
          dat_drv_d = 1'b1;
          to_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + IW'(1);
          dat_drv_d = ((inh_cnt_q + IW'(1)) == INH_LAST);
        end
      end
      S_REQ, S_SHIFT, S_WAIT_IDLE: begin
        if (timeout) begin
          clk_drv_d = 1'b0;
          dat_drv_d = 1'b0;
          ack_d     = 1'b0;
          state_d   = S_FAULT;
        end else if (fe) begin
          to_cnt_d = '0;
          // Falling edges after the ACK edge only restart the idle timeout.
          if (state_q != S_WAIT_IDLE) begin
            bit_cnt_d = bit_n;
            state_d   = S_SHIFT;
            if (bit_n <= 4'd8) begin
              dat_drv_d = ~byte_q[bit_cnt_q[2:0]];
            end else if (bit_n == 4'd9) begin
              dat_drv_d = ~par;
            end else if (bit_n == 4'd10) begin
              dat_drv_d = 1'b0;
            end else begin
              ack_d   = ~dat_s;
              state_d = S_WAIT_IDLE;
            end
          end
        end else if (state_q == S_WAIT_IDLE && clk_s && dat_s) begin
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_q     <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      clk_drv_q  <= 1'b0;
      dat_drv_q  <= 1'b0;
      ack_q      <= 1'b0;
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      clk_drv_q  <= clk_drv_d;
      dat_drv_q  <= dat_drv_d;
      ack_q      <= ack_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign ps2_clk_drive_low = clk_drv_q;
  assign ps2_dat_drive_low = dat_drv_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign error             = (state_q == S_FAULT);
  assign ack_ok            = ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model with a scripted PS/2 device, table-driven
// frames plus hand-written timeout, reset and ignored-send sequences.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int TO   = 500;
  localparam int HALF = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_drive_low, ps2_dat_drive_low;
  logic       busy, done, ack_ok, error;
  logic       clk_pin, dat_pin;

  assign clk_pin = ~(ps2_clk_drive_low | dev_clk_low);
  assign dat_pin = ~(ps2_dat_drive_low | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .send(send), .tx_byte(tx_byte),
    .ps2_clk_in(clk_pin), .ps2_dat_in(dat_pin),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_dat_drive_low(ps2_dat_drive_low),
    .busy(busy), .done(done), .ack_ok(ack_ok), .error(error)
  );

  always #5 clock = ~clock;

  int   compared = 0;
  int   mismatched = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic ack_at_done = 1'b0;
  logic busy_after = 1'b1;
  logic done_prev = 1'b0;

  always @(negedge clock) begin
    if (done_prev) busy_after = busy;
    if (done) begin
      done_cnt = done_cnt + 1;
      ack_at_done = ack_ok;
    end
    if (error) err_cnt = err_cnt + 1;
    done_prev = done;
  end

  typedef struct {
    logic [7:0] b;
    logic       nack;
    logic [9:0] exp_line;
    logic       exp_ack;
    int         inject;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input int act, input int exp);
    compared = compared + 1;
    if (act != exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    send = 1'b1;
    tx_byte = b;
    @(negedge clock);
    send = 1'b0;
  endtask

  // Measures the request-to-send window and the start bit placement.
  task automatic inhibit_phase();
    int   n = 0;
    logic prev_dat = 1'b0;
    logic last_dat = 1'b0;
    while (ps2_clk_drive_low && n < INH + 100) begin
      prev_dat = last_dat;
      last_dat = ps2_dat_drive_low;
      n++;
      @(negedge clock);
    end
    checkOutput("inhibit_len", n, INH);
    checkOutput("dat_before_final", int'(prev_dat), 0);
    checkOutput("start_in_final", int'(last_dat), 1);
    checkOutput("start_at_release", int'(ps2_dat_drive_low), 1);
  endtask

  task automatic device_bits(input int nfe, input int inject_at, output logic [9:0] seen);
    seen = '0;
    repeat (10) @(negedge clock);
    for (int i = 0; i < nfe; i++) begin
      dev_clk_low = 1'b1;
      if (i + 1 == inject_at) begin
        send = 1'b1;
        tx_byte = 8'h55;
        @(negedge clock);
        send = 1'b0;
        repeat (HALF - 1) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      if (i < 10) seen[i] = dat_pin;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clock);
    end
  endtask

  task automatic ack_phase(input logic nack);
    dev_dat_low = ~nack;
    repeat (5) @(negedge clock);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clock);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clock);
    dev_dat_low = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int         d0, e0, n;
    logic [9:0] seen;
    applyStimulus(v.b);
    inhibit_phase();
    d0 = done_cnt;
    e0 = err_cnt;
    device_bits(10, v.inject, seen);
    ack_phase(v.nack);
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    repeat (50) @(negedge clock);
    checkOutput("frame_bits", int'(seen), int'(v.exp_line));
    checkOutput("done_count", done_cnt - d0, 1);
    checkOutput("ack_ok_at_done", int'(ack_at_done), int'(v.exp_ack));
    checkOutput("busy_after_done", int'(busy_after), 0);
    checkOutput("no_error", err_cnt - e0, 0);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         d0, e0, k;
    logic [9:0] seen;

    vecs[0] = '{b: 8'hED, nack: 1'b0, exp_line: 10'b1_1_11101101, exp_ack: 1'b1, inject: 0};
    vecs[1] = '{b: 8'hF4, nack: 1'b1, exp_line: 10'b1_0_11110100, exp_ack: 1'b0, inject: 0};
    vecs[2] = '{b: 8'h00, nack: 1'b0, exp_line: 10'b1_1_00000000, exp_ack: 1'b1, inject: 0};
    vecs[3] = '{b: 8'hFF, nack: 1'b1, exp_line: 10'b1_1_11111111, exp_ack: 1'b0, inject: 0};
    vecs[4] = '{b: 8'hED, nack: 1'b0, exp_line: 10'b1_1_11101101, exp_ack: 1'b1, inject: 3};

    repeat (3) @(negedge clock);
    checkOutput("reset_clk_drive", int'(ps2_clk_drive_low), 0);
    checkOutput("reset_dat_drive", int'(ps2_dat_drive_low), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done_error_ack", int'({done, error, ack_ok}), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // Device never clocks: error exactly TO cycles after REQ entry.
    applyStimulus(8'h00);
    inhibit_phase();
    d0 = done_cnt;
    e0 = err_cnt;
    k = 0;
    while (!error && k < TO + 50) begin
      @(negedge clock);
      k++;
    end
    checkOutput("timeout_req_cycles", k, TO);
    checkOutput("timeout_lines", int'({ps2_clk_drive_low, ps2_dat_drive_low}), 0);
    checkOutput("timeout_ack_ok", int'(ack_ok), 0);
    @(negedge clock);
    checkOutput("timeout_busy_next", int'(busy), 0);
    repeat (20) @(negedge clock);
    checkOutput("timeout_no_done", done_cnt - d0, 0);
    checkOutput("timeout_one_error", err_cnt - e0, 1);

    // Device stops after fe5: error TO cycles after fe5 is processed (2 sync + 1).
    applyStimulus(8'hED);
    inhibit_phase();
    d0 = done_cnt;
    device_bits(4, 0, seen);
    repeat (10) @(negedge clock);
    dev_clk_low = 1'b1;
    k = 0;
    while (!error && k < TO + 50) begin
      @(negedge clock);
      k++;
      if (k == HALF) dev_clk_low = 1'b0;
    end
    dev_clk_low = 1'b0;
    checkOutput("stall_fe5_cycles", k, TO + 3);
    checkOutput("stall_lines", int'({ps2_clk_drive_low, ps2_dat_drive_low}), 0);
    repeat (20) @(negedge clock);
    checkOutput("stall_no_done", done_cnt - d0, 0);
    run_vector(vecs[0]);

    // Reset asserted while the device holds fe6 low.
    applyStimulus(8'h00);
    inhibit_phase();
    device_bits(5, 0, seen);
    repeat (10) @(negedge clock);
    dev_clk_low = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("pre_reset_dat_low", int'(ps2_dat_drive_low), 1);
    d0 = done_cnt;
    e0 = err_cnt;
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_lines", int'({ps2_clk_drive_low, ps2_dat_drive_low}), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    checkOutput("reset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    run_vector(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard over the same PS2_CLK/PS2_DAT pins the receive path listens on.
- Performs the request-to-send sequence, then shifts out data bits on device-generated clock edges.
- Checks the device ACK and reports completion or error to the game control FSM.
- Pins are open-drain: the block only ever drives low or releases.

Parameters:
INHIBIT_CYCLES, 6000, system clocks PS2 clock is held low for request-to-send (120 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max system clocks between consecutive device clock falling edges (20 ms), and for the final idle wait
SYNC_STAGES, 2, synchronizer depth on ps2_clk_in/ps2_dat_in (legal values 2 or 3)

Ports:
clock  input  1  system clock (CLOCK_50)
reset  input  1  asynchronous, active-high reset
send  input  1  start request, sampled in IDLE only
tx_byte  input  8  command byte, latched on accepted send
ps2_clk_in  input  1  raw PS2_CLK pin level
ps2_dat_in  input  1  raw PS2_DAT pin level
ps2_clk_drive_low  output  1  1 = pull PS2_CLK low, 0 = release
ps2_dat_drive_low  output  1  1 = pull PS2_DAT low, 0 = release
busy  output  1  high from accepted send until done/error pulse
done  output  1  one-cycle pulse, transfer finished (ACK or NACK)
ack_ok  output  1  valid with done: 1 = device drove ACK low
error  output  1  one-cycle pulse on timeout; done not asserted in that case

Behaviour:
- Reset (async): all outputs 0, state IDLE, both lines released, counters 0.
- Inputs pass through SYNC_STAGES flip-flops. A falling edge (fe) is synced previous=1 and current=0. The bit change lands within SYNC_STAGES+1 clocks of the pin edge.
- Parity is odd: par = ~^latched_byte.
- Frame order: start(0), d0..d7 LSB first, par, stop(1).
- IDLE:
  - send=1 → latch tx_byte, busy=1, go INHIBIT.
  - send while busy is ignored.
- INHIBIT:
  - clk_drive_low=1 for exactly INHIBIT_CYCLES clocks.
  - In the final inhibit cycle set dat_drive_low=1 (start bit), then go REQ.
- REQ:
  - clk released, dat_drive_low=1.
  - Bit counter = 0 and timeout counter starts.
- SHIFT:
  - Entered from REQ.
  - On each fe, bit counter increments. For counter value n after increment: n=1..8 → dat_drive_low = ~d(n-1); n=9 → ~par; n=10 → release data (stop).
  - Data changes only on fe, never otherwise.
- ACK:
  - On the 11th fe, sample synced data: 0 → ack_ok=1, 1 → ack_ok=0. Go WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced clk=1 and dat=1, then go DONE.
  - DONE: done=1 for one cycle, busy=0, return IDLE. ack_ok holds until the next accepted send.
- Timeout:
  - The counter resets on every fe and on entry to REQ.
  - In REQ/SHIFT/ACK/WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines in the same cycle and pulses error one cycle. busy=0 next cycle, state IDLE, ack_ok=0.
- Glitches:
  - A rising edge without a preceding fe is ignored.
  - Extra fe after the 11th (in WAIT_IDLE) is ignored.
- Reset mid-transfer: lines released immediately, no done/error pulse.
- send=1 in the same cycle as the done/error pulse is ignored. A new send is accepted from the following cycle.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → clk held low 6000 cycles. dat low at release. Bits after fe1..8: 1,0,1,1,0,1,1,1. par=1, stop released. done pulse with ack_ok=1, busy low after.
- Send 0xF4 with the device driving data high at fe11 (NACK) → data bits 0,0,1,0,1,1,1,1, par=0. done with ack_ok=0, error=0.
- Send 0x00 with the device never clocking → error pulse exactly TIMEOUT_CYCLES after REQ entry. Both drive_low=0, done never asserted.
- Device stops after the 5th fe → error TIMEOUT_CYCLES after fe5. A subsequent send of 0xED completes normally with ack_ok=1.
- Assert reset at fe6 of a transfer → drive_low outputs 0 asynchronously, busy=0, no done. A post-reset send works.
- Pulse send again during SHIFT with tx_byte=0x55 → ignored. The original byte completes unchanged, exactly one done.
